// File: rtl/sub3_byte_serializer.sv
// Record buffer and byte serializer: queues {mode, k, l} records from sub2 and
// streams them one byte per cycle with first/last markers on a valid/ready port.
module sub3_byte_serializer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_i,
    input  logic [1:0]            sig_j,
    input  logic [0:2][7:0]       sig_k,
    input  logic [7:0]            sig_l [0:2],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [1:0]      mode_mem [DEPTH];
    logic [0:2][7:0] k_mem    [DEPTH];
    logic [0:2][7:0] l_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, load_ptr;
    logic [AW:0]     count;
    logic [1:0]      cur_mode;
    logic [0:2][7:0] cur_k, cur_l, l_packed;
    logic [2:0]      idx, last_idx;
    logic [7:0]      byte_sel;
    logic            xfer, final_hs, push, drop, load;

    assign l_packed = {sig_l[0], sig_l[1], sig_l[2]};

    assign xfer     = out_valid & out_ready;
    assign final_hs = xfer & out_last;
    // A final-byte pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push     = sig_i && (sig_j != 2'd3) && ((count < FULL) || final_hs);
    assign drop     = sig_i && (sig_j != 2'd3) && !push;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_ptr  = rd_ptr;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (final_hs) begin
                    if (count > ONE) begin
                        load     = 1'b1;
                        load_ptr = AW'(rd_ptr + 1'b1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mode_mem[wr_ptr] <= sig_j;
            k_mem[wr_ptr]    <= sig_k;
            l_mem[wr_ptr]    <= l_packed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cur_mode <= 2'd0;
            cur_k    <= '0;
            cur_l    <= '0;
            idx      <= 3'd0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= AW'(wr_ptr + 1'b1);
            if (final_hs)
                rd_ptr <= AW'(rd_ptr + 1'b1);
            if (push && !final_hs)
                count <= count + ONE;
            else if (!push && final_hs)
                count <= count - ONE;
            // The head entry stays queued until its last byte; here we only copy it.
            if (load) begin
                cur_mode <= mode_mem[load_ptr];
                cur_k    <= k_mem[load_ptr];
                cur_l    <= l_mem[load_ptr];
                idx      <= 3'd0;
            end else if (xfer) begin
                idx <= idx + 3'd1;
            end
            if (drop && (drop_cnt != {CNT_W{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        if (cur_mode == 2'd1)
            byte_sel = cur_l[idx[1:0]];
        else if (idx < 3'd3)
            byte_sel = cur_k[idx[1:0]];
        else
            byte_sel = cur_l[2'(idx - 3'd3)];
    end

    assign last_idx  = (cur_mode == 2'd2) ? 3'd5 : 3'd2;
    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? byte_sel : 8'h00;
    assign out_first = out_valid && (idx == 3'd0);
    assign out_last  = out_valid && (idx == last_idx);
    assign busy      = (count != '0) || (state == SEND);

endmodule

// File: tb/tb_sub3_byte_serializer.sv
// Bench for sub3_byte_serializer: directed scenarios plus random traffic, checked
// each cycle against a queue-of-records model of the byte stream.
module tb_sub3_byte_serializer;

    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            sig_i;
    logic [1:0]      sig_j;
    logic [0:2][7:0] sig_k;
    logic [7:0]      sig_l [0:2];
    logic            out_ready;
    logic            out_valid, out_first, out_last, busy;
    logic [7:0]      out_data, drop_cnt;
    logic            out_valid2, out_first2, out_last2, busy2;
    logic [7:0]      out_data2;
    logic [1:0]      drop_cnt2;

    sub3_byte_serializer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sig_i(sig_i), .sig_j(sig_j), .sig_k(sig_k), .sig_l(sig_l),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
    );

    // Second copy with a 2-bit drop counter, fed identically, to see saturation.
    sub3_byte_serializer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .sig_i(sig_i), .sig_j(sig_j), .sig_k(sig_k), .sig_l(sig_l),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_first(out_first2), .out_last(out_last2), .busy(busy2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] b [6];
    } rec_t;

    rec_t rec_q [$];
    bit   showing;
    int   pos;
    int   drop_m, drop_m2;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dut_xfers;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        bit   fhs, acc, dropped;
        rec_t r;
        if (rst) begin
            rec_q.delete();
            showing = 0; pos = 0; drop_m = 0; drop_m2 = 0;
            return;
        end
        fhs = 0;
        if (showing)
            fhs = out_ready && (pos == rec_q[0].len - 1);
        acc     = sig_i && (sig_j != 2'd3) && ((rec_q.size() < DEPTH) || fhs);
        dropped = sig_i && (sig_j != 2'd3) && !acc;
        if (showing && out_ready) begin
            if (fhs) begin
                void'(rec_q.pop_front());
                pos = 0;
                showing = (rec_q.size() != 0);
            end else begin
                pos++;
            end
        end else if (!showing && rec_q.size() != 0) begin
            showing = 1; pos = 0;
        end
        if (acc) begin
            r.len = (sig_j == 2'd2) ? 6 : 3;
            for (int n = 0; n < 6; n++) r.b[n] = 8'h00;
            for (int n = 0; n < 3; n++) begin
                if (sig_j == 2'd1) r.b[n] = sig_l[n];
                else               r.b[n] = sig_k[n];
                if (sig_j == 2'd2) r.b[n+3] = sig_l[n];
            end
            rec_q.push_back(r);
        end
        if (dropped) begin
            if (drop_m  < 255) drop_m++;
            if (drop_m2 < 3)   drop_m2++;
        end
    endtask

    task automatic checkOutput();
        chk("out_valid", 32'(out_valid), 32'(showing));
        if (showing) begin
            chk("out_data",  32'(out_data),  32'(rec_q[0].b[pos]));
            chk("out_first", 32'(out_first), 32'(pos == 0));
            chk("out_last",  32'(out_last),  32'(pos == rec_q[0].len - 1));
        end
        chk("busy",      32'(busy),      32'(rec_q.size() != 0));
        chk("drop_cnt",  32'(drop_cnt),  32'(drop_m));
        chk("drop_sat",  32'(drop_cnt2), 32'(drop_m2));
    endtask

    // bytes = {k0,k1,k2,l0,l1,l2}
    task automatic applyStimulus(input logic r, input logic i, input logic [1:0] j,
                                 input logic [47:0] bytes, input logic rdy);
        rst       = r;
        sig_i     = i;
        sig_j     = j;
        sig_k     = {bytes[47:40], bytes[39:32], bytes[31:24]};
        sig_l[0]  = bytes[23:16];
        sig_l[1]  = bytes[15:8];
        sig_l[2]  = bytes[7:0];
        out_ready = rdy;
        if (out_valid && rdy) dut_xfers++;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 2'd0, 48'h0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_first", 32'(out_first), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
    endtask

    initial begin
        rst = 1'b1; sig_i = 1'b0; sig_j = 2'd0; sig_k = '0; out_ready = 1'b0;
        for (int n = 0; n < 3; n++) sig_l[n] = 8'h00;
        showing = 0; pos = 0; drop_m = 0; drop_m2 = 0; dut_xfers = 0;
        @(negedge clk);
        doReset();

        $display("[TB] single mode-2 record");
        applyStimulus(1'b0, 1'b1, 2'd2, 48'h112233445566, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_first", 32'(out_first), 32'd1);
        chk("first_byte",    32'(out_data),  32'h11);
        idle(8, 1'b1);
        chk("busy_falls", 32'(busy), 32'd0);

        $display("[TB] back-pressure");
        applyStimulus(1'b0, 1'b1, 2'd0, 48'hA1B2C3000000, 1'b0);
        begin
            logic [5:0] pat = 6'b101001;
            applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b0);
            for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, pat[c]);
        end
        idle(3, 1'b1);

        $display("[TB] back-to-back");
        applyStimulus(1'b0, 1'b1, 2'd1, 48'h000000010203, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd1, 48'h000000040506, 1'b1);
        idle(8, 1'b1);

        $display("[TB] overflow");
        doReset();
        for (int c = 0; c < 4; c++)
            applyStimulus(1'b0, 1'b1, 2'd0, {8'(c), 40'h1020304050}, 1'b0);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        dut_xfers = 0;
        idle(10, 1'b1);
        chk("ovf_bytes", 32'(dut_xfers), 32'd6);

        $display("[TB] push with final pop at full");
        doReset();
        applyStimulus(1'b0, 1'b1, 2'd0, 48'hAABBCC000000, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 48'hDDEEFF000000, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd0, 48'h778899000000, 1'b1);
        chk("full_pop_push_drop", 32'(drop_cnt), 32'd0);
        idle(10, 1'b1);

        $display("[TB] discard and saturation");
        applyStimulus(1'b0, 1'b1, 2'd3, 48'h123456789ABC, 1'b1);
        idle(3, 1'b1);
        chk("discard_valid", 32'(out_valid), 32'd0);
        chk("discard_drop",  32'(drop_cnt),  32'd0);
        for (int c = 0; c < 7; c++)
            applyStimulus(1'b0, 1'b1, 2'd1, 48'h000000C0FFEE, 1'b0);
        chk("sat_drop8", 32'(drop_cnt),  32'd5);
        chk("sat_drop2", 32'(drop_cnt2), 32'd3);
        idle(10, 1'b1);

        $display("[TB] reset mid-record");
        applyStimulus(1'b0, 1'b1, 2'd2, 48'h0A0B0C0D0E0F, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        doReset();
        applyStimulus(1'b0, 1'b1, 2'd0, 48'h5A6B7C000000, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 48'h0, 1'b1);
        chk("post_rst_first", 32'(out_first), 32'd1);
        chk("post_rst_data",  32'(out_data),  32'h5A);
        idle(4, 1'b1);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            logic        ri, rr;
            logic [1:0]  rj;
            logic [47:0] rb;
            ri = ($urandom_range(0, 99) < 45);
            rj = 2'($urandom_range(0, 3));
            rb = 48'({$urandom(), $urandom()});
            rr = ($urandom_range(0, 99) < 70);
            applyStimulus(($urandom_range(0, 199) == 0), ri, rj, rb, rr);
        end
        idle(20, 1'b1);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub3_byte_serializer.md
Name: sub3_byte_serializer

Overview:
- Downstream stage of sub2. Consumes sub2's outputs: sig_i (record strobe), sig_j (mode), sig_k (packed 3-byte vector) and sig_l (unpacked 3-byte array).
- Buffers records in a small FIFO and emits them one byte per cycle on a valid/ready byte stream, with first/last markers.
- Feeds the byte-wide egress path.
- sub2 has no back-pressure input, so records arriving while the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 2, number of record entries in the FIFO (>=2, power of 2).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_i  input  1  record strobe from sub2; one record per high cycle.
- sig_j  input  2  mode: 0 = k bytes only, 1 = l bytes only, 2 = k then l, 3 = discard.
- sig_k  input  [0:2][7:0]  packed record bytes; byte order k[0], k[1], k[2].
- sig_l  input  [7:0] x [0:2] unpacked  record bytes; byte order l[0], l[1], l[2].
- out_valid  output  1  byte available.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  current byte.
- out_first  output  1  high with the first byte of a record.
- out_last  output  1  high with the final byte of a record.
- busy  output  1  FIFO non-empty or FSM in SEND.
- drop_cnt  output  CNT_W  saturating count of records lost to overflow.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: FIFO empty; FSM to IDLE; out_valid, out_data, out_first, out_last, busy = 0; drop_cnt = 0.
  - Reset mid-record aborts the stream: no out_last is emitted and the partial record is discarded.
- Push: on a cycle with sig_i=1 and sig_j!=3, {sig_j, sig_k, sig_l} is written to the FIFO tail if either:
  - count < DEPTH, or
  - the final-byte handshake (out_valid & out_ready & out_last) occurs in the same cycle.
  Otherwise the record is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- Discard: sig_i=1 with sig_j=3 writes nothing and does not count as a drop.
- Handshake: transfer occurs when out_valid & out_ready. While out_valid=1 and out_ready=0, out_data, out_first and out_last hold stable. out_valid never drops without a transfer, except on rst.
- Sequence per mode (out_first on byte 0, out_last on the final byte):
  - mode 0: 3 bytes, k[0..2].
  - mode 1: 3 bytes, l[0..2].
  - mode 2: 6 bytes, k[0..2] then l[0..2]; index runs 0..5.
- FSM:
  - IDLE -> SEND when the FIFO is non-empty. Loads the head entry and sets byte index 0. out_valid is registered and asserts on that edge.
  - SEND, non-final handshake: index+1, stay in SEND.
  - SEND, final handshake: pop the head.
    - If another entry remains, load it at the same edge, index 0, stay in SEND. Back-to-back records have zero bubble.
    - Else go to IDLE; out_valid = 0.
  - The head entry stays in the FIFO until its final-byte handshake.
- Latency: sig_i high in cycle 0 with the FIFO empty and FSM idle gives out_valid=1 and out_first=1 in cycle 2.
- Simultaneous push and final pop at full: both succeed; count unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- busy = (count != 0) | (state == SEND), registered-consistent with the state.

Test Plan:
- Single mode-2 record: k=[11,22,33], l=[44,55,66], out_ready=1 -> out_valid rises in cycle 2. Bytes 11,22,33,44,55,66 on consecutive cycles; first on 11, last on 66; busy then falls.
- Back-pressure: mode 0, k=[A1,B2,C3], out_ready toggling 1,0,0,1,0,1 -> each byte held stable while stalled. Stream is A1,B2,C3 with no duplicates or skips.
- Back-to-back: two mode-1 records pushed on consecutive cycles -> 6 bytes with no gap; out_last on byte 3 and out_first on byte 4.
- Overflow: DEPTH=2, out_ready=0, four mode-0 pushes -> first two stored, drop_cnt=2. Release out_ready -> exactly 6 bytes out. Push coinciding with a final pop at full is accepted.
- Discard and saturation: mode-3 push -> no output, drop_cnt unchanged. With CNT_W=2, force 5 overflows -> drop_cnt=3.
- Reset mid-record: assert rst after byte 1 of a mode-2 record -> next cycle out_valid=0, busy=0, drop_cnt=0. A new push afterwards streams normally from its first byte.
